// File: rtl/if_stage_unit_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory port and IF/ID outputs.
// With IF_STALL_CNT_EN defined the bundle also carries the 32-bit stall_cnt.
interface if_stage_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               freeze;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_addr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_valid;
`ifdef IF_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  // master = the fetch stage, slave = hazard unit / EXE / imem / decode side
  modport master (
    input  freeze,
    input  branch_taken,
    input  branch_addr,
    input  imem_rdata,
    output imem_addr,
    output id_pc,
    output id_instr,
    output id_valid
`ifdef IF_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output freeze,
    output branch_taken,
    output branch_addr,
    output imem_rdata,
    input  imem_addr,
    input  id_pc,
    input  id_instr,
    input  id_valid
`ifdef IF_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional saturating stall counter enabled by defining IF_STALL_CNT_EN.
module if_stage_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 PC_STEP   = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic           clk,
  input  logic           rst,
  if_stage_unit_if.master bus_io
);

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_HOLD,
    ACT_REDIRECT
  } act_e;

  act_e               act;
  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [ADDR_W-1:0]  id_pc_q,    id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]  pc_plus;

  assign pc_plus = pc_q + ADDR_W'(PC_STEP);

  // A redirect always wins over a stall so the branch target is never dropped.
  always_comb begin
    act = ACT_RUN;
    if (bus_io.branch_taken) begin
      act = ACT_REDIRECT;
    end else if (bus_io.freeze) begin
      act = ACT_HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    case (act)
      ACT_REDIRECT: begin
        pc_d       = bus_io.branch_addr;
        id_pc_d    = '0;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
      ACT_RUN: begin
        pc_d       = pc_plus;
        id_pc_d    = pc_plus;
        id_instr_d = bus_io.imem_rdata;
        id_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  // imem_addr comes straight from the PC register: no path from freeze/branch.
  assign bus_io.imem_addr = pc_q;
  assign bus_io.id_pc     = id_pc_q;
  assign bus_io.id_instr  = id_instr_q;
  assign bus_io.id_valid  = id_valid_q;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (act == ACT_HOLD && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_io.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed bench for if_stage_unit: reset, run, freeze, redirect, wrap, async reset.
// Stall-count checks are active when IF_STALL_CNT_EN is defined.
module tb_if_stage_unit;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  if_stage_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  if_stage_unit #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .NOP_INSTR(32'h0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns an address-derived word in the same cycle.
  assign bus.imem_rdata = 32'hC0DE_0000 + bus.imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                        input logic [31:0] instr, input logic vld);
    chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".id_pc"},     bus.id_pc, pc);
    chk({tag, ".id_instr"},  bus.id_instr, instr);
    chk({tag, ".id_valid"},  {31'd0, bus.id_valid}, {31'd0, vld});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef IF_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, bus.stall_cnt, exp);
`else
    if (exp == 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d frz=%0b br=%0b imem_addr=%h id_pc=%h id_instr=%h id_valid=%0b",
             step_no, bus.freeze, bus.branch_taken, bus.imem_addr, bus.id_pc,
             bus.id_instr, bus.id_valid);
  endtask

  initial begin
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = 32'h0;
    #1;
    chk_id("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("reset", 32'd0);
    step(); step(); step();
    chk_id("reset_held", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // run
    step();
    chk_id("run1", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1);
    step();
    chk_id("run2", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1);

    // freeze 3 cycles at pc=8
    bus.freeze = 1'b1;
    step(); step(); step();
    chk_id("freeze3", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1);
    chk_cnt("freeze3", 32'd3);
    bus.freeze = 1'b0;
    step();
    chk_id("resume", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1);
    chk_cnt("resume", 32'd3);
    step();
    chk_id("run3", 32'h10, 32'h10, 32'hC0DE_000C, 1'b1);

    // branch at pc=0x10
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h40;
    step();
    chk_id("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    chk_id("branch_tgt", 32'h44, 32'h44, 32'hC0DE_0040, 1'b1);

    // simultaneous freeze + branch
    bus.freeze = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h80;
    step();
    chk_id("simul", 32'h80, 32'h0, 32'h0, 1'b0);
    chk_cnt("simul", 32'd3);
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    step();
    chk_id("simul_tgt", 32'h84, 32'h84, 32'hC0DE_0080, 1'b1);

    // freeze while a bubble sits in ID
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h100;
    step();
    bus.branch_taken = 1'b0;
    bus.freeze = 1'b1;
    step();
    chk_id("frz_bubble", 32'h100, 32'h0, 32'h0, 1'b0);
    chk_cnt("frz_bubble", 32'd4);
    bus.freeze = 1'b0;
    step();
    chk_id("bubble_go", 32'h104, 32'h104, 32'hC0DE_0100, 1'b1);

    // PC wrap from 0xFFFF_FFFC
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'hFFFF_FFFC;
    step();
    chk_id("wrap_ld", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    bus.branch_taken = 1'b0;
    step();
    chk_id("wrap", 32'h0, 32'h0, 32'hC0DD_FFFC, 1'b1);

    // async reset between edges at pc=0x20
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h1C;
    step();
    bus.branch_taken = 1'b0;
    step();
    chk_id("pre_arst", 32'h20, 32'h20, 32'hC0DE_001C, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_id("arst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("arst", 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk_id("post_arst", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
